// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default sizes, clog2 and
// pointer-compare helpers for the full/empty flags.
package fifo_pkg;

    localparam int DEF_DATA_W = 512;
    localparam int DEF_DEPTH  = 256;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Equal pointers (including wrap bit) mean nothing is held.
    function automatic logic ptr_empty(
        input logic [31:0] w,
        input logic [31:0] r
    );
        return w == r;
    endfunction

    // Wrap bits differ while the index bits match: all entries held.
    function automatic logic ptr_full(
        input logic [31:0] w,
        input logic [31:0] r,
        input int          aw
    );
        logic [31:0] m;
        m = (32'd1 << aw) - 32'd1;
        return (w[aw] != r[aw]) && ((w & m) == (r & m));
    endfunction

endpackage

// File: rtl/fifo_ram_1r1w.sv
// Storage array for sync_fifo_param: synchronous write port,
// read port either combinational (FWFT) or registered.
module fifo_ram_1r1w
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int FWFT   = 1,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are never cleared; only the write port touches them.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    if (FWFT != 0) begin : g_async
        logic unused_rd;
        assign unused_rd = reset ^ re;
        assign rdata = mem[raddr];
    end else begin : g_reg
        logic [DATA_W-1:0] q;
        // Output register loads only on an accepted read, holds otherwise.
        always_ff @(posedge clk or posedge reset) begin
            if (reset)   q <= '0;
            else if (re) q <= mem[raddr];
        end
        assign rdata = q;
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO: pointers, occupancy, flags and sticky
// errors around a 1R1W array, with FWFT or registered reads.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    wr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic                    rd,
    output logic [DATA_W-1:0]       rdata,
    output logic                    rdata_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [clog2(DEPTH):0]   count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int ADDR_W = clog2(DEPTH);

    logic [ADDR_W:0]   wptr;
    logic [ADDR_W:0]   rptr;
    logic [ADDR_W:0]   cnt;
    logic              ovf;
    logic              unf;
    logic              rv_q;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] ram_q;

    assign empty  = ptr_empty(32'(wptr), 32'(rptr));
    assign full   = ptr_full(32'(wptr), 32'(rptr), ADDR_W);
    assign wr_acc = wr & ~full;
    assign rd_acc = rd & ~empty;

    assign count        = cnt;
    assign almost_full  = int'(cnt) >= AF_THRESH;
    assign almost_empty = int'(cnt) <= AE_THRESH;
    assign overflow     = ovf;
    assign underflow    = unf;

    // Pointer, count and error state; flush wins over any request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
            rv_q <= 1'b0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
            rv_q <= 1'b0;
        end else begin
            if (wr_acc) wptr <= wptr + 1'b1;
            if (rd_acc) rptr <= rptr + 1'b1;
            if (wr_acc && !rd_acc) cnt <= cnt + 1'b1;
            if (rd_acc && !wr_acc) cnt <= cnt - 1'b1;
            if (wr && full)  ovf <= 1'b1;
            if (rd && empty) unf <= 1'b1;
            rv_q <= rd_acc;
        end
    end

    fifo_ram_1r1w #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .FWFT   (FWFT),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_acc & ~flush),
        .waddr (wptr[ADDR_W-1:0]),
        .wdata (wdata),
        .re    (rd_acc & ~flush),
        .raddr (rptr[ADDR_W-1:0]),
        .rdata (ram_q)
    );

    // While empty the FWFT head is meaningless, so present zero.
    assign rdata = (FWFT != 0) ? (empty ? '0 : ram_q) : ram_q;
    assign rdata_valid = (FWFT != 0) ? ~empty : rv_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: FWFT and registered instances share
// stimulus and are compared against a queue model every cycle.
module tb_sync_fifo_param;

    localparam int W = 32;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         flush = 1'b0;
    logic         wr = 1'b0;
    logic         rd = 1'b0;
    logic [W-1:0] wdata = '0;

    logic [W-1:0] rdata_a, rdata_b;
    logic         rv_a, rv_b, full_a, full_b, empty_a, empty_b;
    logic         af_a, af_b, ae_a, ae_b;
    logic         ovf_a, ovf_b, unf_a, unf_b;
    logic [3:0]   count_a, count_b;

    int checks = 0;
    int failures = 0;

    sync_fifo_param #(
        .DATA_W(W), .DEPTH(D), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)
    ) dut_a (
        .clk(clk), .reset(reset), .flush(flush), .wr(wr), .wdata(wdata),
        .rd(rd), .rdata(rdata_a), .rdata_valid(rv_a), .full(full_a),
        .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a),
        .count(count_a), .overflow(ovf_a), .underflow(unf_a)
    );

    sync_fifo_param #(
        .DATA_W(W), .DEPTH(D), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)
    ) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .wr(wr), .wdata(wdata),
        .rd(rd), .rdata(rdata_b), .rdata_valid(rv_b), .full(full_b),
        .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b),
        .count(count_b), .overflow(ovf_b), .underflow(unf_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, errors as sticky bits.
    logic [W-1:0] q[$];
    bit           m_ovf, m_unf, m_rv0;
    logic [W-1:0] m_rd0;

    always @(posedge clk or posedge reset) begin
        bit f, e;
        if (reset) begin
            q.delete();
            m_ovf = 0; m_unf = 0; m_rv0 = 0; m_rd0 = '0;
        end else if (flush) begin
            q.delete();
            m_ovf = 0; m_unf = 0; m_rv0 = 0;
        end else begin
            f = (q.size() == D);
            e = (q.size() == 0);
            m_rv0 = 0;
            if (wr && f) m_ovf = 1;
            if (rd && e) m_unf = 1;
            if (rd && !e) begin
                m_rd0 = q.pop_front();
                m_rv0 = 1;
            end
            if (wr && !f) q.push_back(wdata);
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        int n;
        n = q.size();
        check("cnt_a", count_a, n);
        check("cnt_b", count_b, n);
        check("empty_a", empty_a, n == 0);
        check("empty_b", empty_b, n == 0);
        check("full_a", full_a, n == D);
        check("full_b", full_b, n == D);
        check("af_a", af_a, n >= 6);
        check("af_b", af_b, n >= 6);
        check("ae_a", ae_a, n <= 2);
        check("ae_b", ae_b, n <= 2);
        check("ovf_a", ovf_a, m_ovf);
        check("ovf_b", ovf_b, m_ovf);
        check("unf_a", unf_a, m_unf);
        check("unf_b", unf_b, m_unf);
        check("rv_a", rv_a, n != 0);
        if (n != 0) check("rdata_a", rdata_a, q[0]);
        check("rv_b", rv_b, m_rv0);
        check("rdata_b", rdata_b, m_rd0);
    end

    task automatic step(input bit w, input logic [W-1:0] d,
                        input bit r, input bit f);
        wr = w; wdata = d; rd = r; flush = f;
        @(posedge clk);
        #2;
        wr = 0; rd = 0; flush = 0;
    endtask

    initial begin
        #1 reset = 1;
        @(posedge clk);
        #2;
        check("rst_empty", empty_a, 1);
        check("rst_full", full_a, 0);
        check("rst_count", count_a, 0);
        check("rst_ae", ae_a, 1);
        check("rst_ovf", ovf_a, 0);
        check("rst_rdata_a", rdata_a, 0);
        check("rst_rdata_b", rdata_b, 0);
        check("rst_rv_b", rv_b, 0);
        reset = 0;

        // 1: fill
        for (int i = 0; i < 8; i++) begin
            step(1, 32'h10 + i, 0, 0);
            check("t1_af", af_a, (i + 1) >= 6);
        end
        check("t1_full", full_a, 1);
        check("t1_count", count_a, 8);

        // 2: overflow, drain, underflow
        step(1, 32'hDEAD, 0, 0);
        check("t2_ovf", ovf_a, 1);
        check("t2_count", count_a, 8);
        for (int i = 0; i < 8; i++) begin
            check("t2_head", rdata_a, 32'h10 + i);
            step(0, 0, 1, 0);
            check("t2_rdata_b", rdata_b, 32'h10 + i);
        end
        check("t2_empty", empty_a, 1);
        step(0, 0, 1, 0);
        check("t2_unf", unf_a, 1);
        check("t2_cnt0", count_a, 0);

        // 3: streaming at count 4 through pointer wrap
        step(0, 0, 0, 1);
        check("t3_unf_clr", unf_a, 0);
        for (int i = 0; i < 4; i++) step(1, 32'h100 + i, 0, 0);
        for (int i = 0; i < 20; i++) begin
            check("t3_head", rdata_a, 32'h100 + i);
            step(1, 32'h104 + i, 1, 0);
            check("t3_count", count_a, 4);
            check("t3_rdata_b", rdata_b, 32'h100 + i);
        end

        // 4: registered read latency and hold
        step(0, 0, 0, 1);
        step(1, 32'hA5, 0, 0);
        check("t4_rv_pre", rv_b, 0);
        step(0, 0, 1, 0);
        check("t4_rdata", rdata_b, 32'hA5);
        check("t4_rv", rv_b, 1);
        step(0, 0, 0, 0);
        check("t4_hold", rdata_b, 32'hA5);
        check("t4_rv_low", rv_b, 0);

        // 5: flush beats a write
        step(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 32'h200 + i, 0, 0);
        step(1, 32'h2FF, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        check("t5_count5", count_a, 5);
        check("t5_ovf", ovf_a, 1);
        step(1, 32'h77, 0, 1);
        check("t5_count0", count_a, 0);
        check("t5_empty", empty_a, 1);
        check("t5_ovf_clr", ovf_a, 0);
        step(0, 0, 0, 0);
        check("t5_discard", count_a, 0);

        // 6: asynchronous reset mid-burst
        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 32'h300 + i, 0, 0);
        check("t6_count3", count_a, 3);
        wr = 1; wdata = 32'h3AA;
        #1 reset = 1;
        #1;
        check("t6_count", count_a, 0);
        check("t6_empty", empty_a, 1);
        check("t6_ae", ae_a, 1);
        check("t6_rv_a", rv_a, 0);
        check("t6_rdata_b", rdata_b, 0);
        wr = 0;
        @(posedge clk);
        #2 reset = 0;
        step(1, 32'h5A, 0, 0);
        check("t6_first", rdata_a, 32'h5A);
        check("t6_cnt1", count_a, 1);
        step(0, 0, 1, 0);
        check("t6_first_b", rdata_b, 32'h5A);

        @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
